// File: rtl/skip_adder_accumulator_if.sv
// Operand and result streams of the skip-adder accumulator.
// master = producer/consumer side, slave = accumulator side.
interface skip_adder_accumulator_if #(
   parameter int WIDTH   = 32,
   parameter int COUNT_W = 8
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_data;
   logic               in_last;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out_sum;
   logic               out_cout;
   logic               out_overflow;
   logic [COUNT_W-1:0] out_count;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_overflow, out_count
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_overflow, out_count
   );
endinterface

// File: rtl/skip_adder_accumulator.sv
// Streaming signed packet accumulator built on a 4-bit-block carry-skip adder.
// Beats are summed one per cycle; the packet total and sticky carry/overflow
// flags are held on the output stream until the consumer takes them.

// One 4-bit ripple block with a skip path: when every bit propagates, the
// block carry-out is the carry-in and bypasses the ripple chain.
module csa_block (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);
   logic [3:0] p;
   logic [3:0] g;
   logic       rip_cout;

   assign p = a ^ b;
   assign g = a & b;

   // ripple carry inside the block
   always_comb begin
      logic [4:0] rc;
      rc    = '0;
      sum   = '0;
      rc[0] = cin;
      for (int i = 0; i < 4; i++) begin
         sum[i]  = p[i] ^ rc[i];
         rc[i+1] = g[i] | (p[i] & rc[i]);
      end
      rip_cout = rc[4];
   end

   assign cout = (&p) ? cin : rip_cout;
endmodule

// N-bit carry-skip adder; N must be a multiple of 4.
module CarrySkipAdder #(
   parameter int N = 32
) (
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         Cin,
   output logic [N-1:0] Sum,
   output logic         Cout,
   output logic         Overflow
);
   localparam int NB = N / 4;

   logic [NB:0] c;

   assign c[0] = Cin;

   generate
      for (genvar k = 0; k < NB; k++) begin : g_blk
         csa_block u_blk (
            .a    (A[4*k +: 4]),
            .b    (B[4*k +: 4]),
            .cin  (c[k]),
            .sum  (Sum[4*k +: 4]),
            .cout (c[k+1])
         );
      end
   endgenerate

   assign Cout     = c[NB];
   // signed overflow: operands agree in sign, result does not
   assign Overflow = (A[N-1] == B[N-1]) & (Sum[N-1] != A[N-1]);
endmodule

module skip_adder_accumulator #(
   parameter int WIDTH   = 32,
   parameter int COUNT_W = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   skip_adder_accumulator_if.slave bus
);
   localparam logic [0:0] ACCUM = 1'b0;
   localparam logic [0:0] HOLD  = 1'b1;

   logic [0:0]         state;
   logic [WIDTH-1:0]   acc;
   logic [COUNT_W-1:0] cnt;
   logic               c_st;
   logic               v_st;

   logic [WIDTH-1:0]   out_sum_r;
   logic [COUNT_W-1:0] out_count_r;
   logic               out_cout_r;
   logic               out_ovf_r;

   logic [WIDTH-1:0]   sum;
   logic               add_cout;
   logic               add_ovf;
   logic [COUNT_W-1:0] cnt_inc;
   logic               beat;
   logic               xfer;

   CarrySkipAdder #(.N(WIDTH)) u_add (
      .A        (acc),
      .B        (bus.in_data),
      .Cin      (1'b0),
      .Sum      (sum),
      .Cout     (add_cout),
      .Overflow (add_ovf)
   );

   assign bus.in_ready     = (state == ACCUM);
   assign bus.out_valid    = (state == HOLD);
   assign bus.out_sum      = out_sum_r;
   assign bus.out_count    = out_count_r;
   assign bus.out_cout     = out_cout_r;
   assign bus.out_overflow = out_ovf_r;

   assign beat    = bus.in_valid & bus.in_ready;
   assign xfer    = bus.out_valid & bus.out_ready;
   // beat count sticks at all-ones; accumulation carries on regardless
   assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

   // accumulate beats, latch the packet result on the last beat, release on transfer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ACCUM;
         acc         <= '0;
         cnt         <= '0;
         c_st        <= 1'b0;
         v_st        <= 1'b0;
         out_sum_r   <= '0;
         out_count_r <= '0;
         out_cout_r  <= 1'b0;
         out_ovf_r   <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (beat) begin
                  if (bus.in_last) begin
                     out_sum_r   <= sum;
                     out_count_r <= cnt_inc;
                     out_cout_r  <= c_st | add_cout;
                     out_ovf_r   <= v_st | add_ovf;
                     acc         <= '0;
                     cnt         <= '0;
                     c_st        <= 1'b0;
                     v_st        <= 1'b0;
                     state       <= HOLD;
                  end else begin
                     acc  <= sum;
                     cnt  <= cnt_inc;
                     c_st <= c_st | add_cout;
                     v_st <= v_st | add_ovf;
                  end
               end
            end
            default: begin
               // outputs keep their values after transfer; only out_valid drops
               if (xfer) state <= ACCUM;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_skip_adder_accumulator.sv
// Directed bench for skip_adder_accumulator: drives on the falling edge,
// checks on the falling edge after each rising edge.
module tb_skip_adder_accumulator;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   skip_adder_accumulator_if #(.WIDTH(32), .COUNT_W(8)) bus ();

   skip_adder_accumulator #(.WIDTH(32), .COUNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // present one beat; it is taken on the next rising edge when in_ready=1
   task automatic send(input logic [31:0] d, input logic l);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = l;
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic chk_res(input string tag, input logic [31:0] s, input logic [31:0] n,
                          input logic c, input logic v);
      chk({tag, ".valid"}, {31'd0, bus.out_valid}, 32'd1);
      chk({tag, ".in_rdy"}, {31'd0, bus.in_ready}, 32'd0);
      chk({tag, ".sum"}, bus.out_sum, s);
      chk({tag, ".count"}, {24'd0, bus.out_count}, n);
      chk({tag, ".cout"}, {31'd0, bus.out_cout}, {31'd0, c});
      chk({tag, ".ovf"}, {31'd0, bus.out_overflow}, {31'd0, v});
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // reset state
      chk("rst.in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst.out_sum", bus.out_sum, 32'd0);
      chk("rst.out_count", {24'd0, bus.out_count}, 32'd0);
      chk("rst.flags", {30'd0, bus.out_cout, bus.out_overflow}, 32'd0);

      // single beat
      send(32'h5, 1'b1);
      chk_res("single", 32'h5, 32'd1, 1'b0, 1'b0);
      @(negedge clk);
      chk("single.after.in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("single.after.valid", {31'd0, bus.out_valid}, 32'd0);
      chk("single.after.sum_kept", bus.out_sum, 32'h5);

      // 10, -3, 7: carry out on 10 + -3
      send(32'd10, 1'b0);
      chk("p3.mid.valid", {31'd0, bus.out_valid}, 32'd0);
      send(32'hFFFF_FFFD, 1'b0);
      chk("p3.mid.in_ready", {31'd0, bus.in_ready}, 32'd1);
      send(32'd7, 1'b1);
      chk_res("p3", 32'd14, 32'd3, 1'b1, 1'b0);
      @(negedge clk);

      // positive overflow
      send(32'h7FFF_FFFF, 1'b0);
      send(32'h1, 1'b1);
      chk_res("povf", 32'h8000_0000, 32'd2, 1'b0, 1'b1);
      @(negedge clk);

      // unsigned carry, no signed overflow
      send(32'hFFFF_FFFF, 1'b0);
      send(32'h1, 1'b1);
      chk_res("carry", 32'h0, 32'd2, 1'b1, 1'b0);
      @(negedge clk);

      // intermediate overflow stays sticky
      send(32'h7FFF_FFFF, 1'b0);
      send(32'h1, 1'b0);
      send(32'hFFFF_FFFF, 1'b1);
      chk_res("sticky", 32'h7FFF_FFFF, 32'd3, 1'b1, 1'b1);
      @(negedge clk);

      // backpressure: result held, offered beats refused
      bus.out_ready = 1'b0;
      send(32'd20, 1'b0);
      send(32'd22, 1'b1);
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 32'd99;
         bus.in_last  = 1'b1;
         chk_res("bp", 32'd42, 32'd2, 1'b0, 1'b0);
         @(negedge clk);
      end
      bus.in_valid  = 1'b0;
      chk_res("bp.end", 32'd42, 32'd2, 1'b0, 1'b0);
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp.rel.valid", {31'd0, bus.out_valid}, 32'd0);
      chk("bp.rel.in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("bp.rel.sum_kept", bus.out_sum, 32'd42);

      // beat counter saturation: 260 beats of 1
      for (int i = 0; i < 259; i++) send(32'h1, 1'b0);
      send(32'h1, 1'b1);
      chk_res("sat", 32'd260, 32'd255, 1'b0, 1'b0);
      @(negedge clk);

      // reset mid-packet
      send(32'd100, 1'b0);
      send(32'd200, 1'b0);
      rst = 1'b1;
      #1;
      chk("midrst.out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("midrst.in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("midrst.out_sum", bus.out_sum, 32'd0);
      chk("midrst.out_count", {24'd0, bus.out_count}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      send(32'd1, 1'b0);
      send(32'd2, 1'b1);
      chk_res("fresh", 32'd3, 32'd2, 1'b0, 1'b0);
      @(negedge clk);

      // reset during HOLD drops the pending result
      bus.out_ready = 1'b0;
      send(32'd9, 1'b1);
      chk("hrst.pre.valid", {31'd0, bus.out_valid}, 32'd1);
      rst = 1'b1;
      #1;
      chk("hrst.valid", {31'd0, bus.out_valid}, 32'd0);
      chk("hrst.sum", bus.out_sum, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("hrst.idle.in_ready", {31'd0, bus.in_ready}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/skip_adder_accumulator.md
# skip_adder_accumulator

Streaming signed accumulator built around the team's 32-bit carry-skip adder. It consumes a packet of operands over a valid/ready stream, sums them into an internal register one beat per cycle, and presents the packet total with sticky carry and overflow flags on a valid/ready output stream. It sits directly downstream of operand producers and feeds result consumers. Its datapath adder is `CarrySkipAdder`, instantiated with `N = WIDTH` and wired with `A` = accumulator and `B` = `in_data`.

## Interface
- `WIDTH`, default 32: operand and sum width; must be a multiple of 4.
- `COUNT_W`, default 8: width of the beat counter.
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: operand beat valid.
- `in_ready`, output, 1: block can accept a beat.
- `in_data`, input, WIDTH: signed two's-complement operand.
- `in_last`, input, 1: beat is the final beat of its packet.
- `out_valid`, output, 1: result is valid.
- `out_ready`, input, 1: consumer accepts the result.
- `out_sum`, output, WIDTH: signed packet total, wrapped modulo 2^WIDTH.
- `out_cout`, output, 1: sticky OR of the adder `Cout` over all beats of the packet.
- `out_overflow`, output, 1: sticky OR of the adder `Overflow` over all beats of the packet.
- `out_count`, output, COUNT_W: number of beats in the packet, saturating at 2^COUNT_W-1.

## Operation
- FSM has two states.
  - ACCUM: reset state.
  - HOLD: a result is being presented.
- Internal registers:
  - `acc`, WIDTH bits.
  - `cnt`, COUNT_W bits.
  - `c_st`, 1 bit.
  - `v_st`, 1 bit.
- `in_ready = (state == ACCUM)`.
- `out_valid = (state == HOLD)`.
- Handshakes: an accepted beat is `in_valid & in_ready`. A transfer is `out_valid & out_ready`.
- ACCUM, accepted beat with `in_last = 0`:
  - `acc <= sum`.
  - `cnt <= cnt + 1`, saturating.
  - `c_st <= c_st | Cout`.
  - `v_st <= v_st | Overflow`.
- ACCUM, accepted beat with `in_last = 1`:
  - `out_sum <= sum`.
  - `out_count <= sat(cnt + 1)`.
  - `out_cout <= c_st | Cout`.
  - `out_overflow <= v_st | Overflow`.
  - `acc`, `cnt`, `c_st` and `v_st` clear to 0.
  - State goes to HOLD.
- ACCUM with no accepted beat: all registers hold.
- HOLD:
  - The output registers are stable until transfer.
  - On transfer the state returns to ACCUM.
  - The output registers keep their last values; only `out_valid` drops.
- Arithmetic:
  - The sum is the adder's modulo-2^WIDTH result; there is no saturation.
  - Overflow is the adder's signed overflow: both inputs have the same sign and the sum sign differs.
  - A single-beat packet adds to `acc = 0`. Its `out_overflow` is therefore 0 and `out_cout` is 0.
- Intermediate overflow is recorded even if later beats bring the total back into range. Example: 0x7FFFFFFF, +1, -1 gives `out_sum = 0x7FFFFFFF` with `out_overflow = 1`.
- `cnt` saturates at all-ones; further beats still accumulate normally.
- `in_data` and `in_last` are ignored when `in_valid = 0` or `in_ready = 0`.
- Reset, including mid-packet or mid-HOLD:
  - All registers go to 0 and the state goes to ACCUM.
  - A partial packet is discarded.
  - A pending result is lost.

## Timing
- Reset values:
  - `in_ready = 1`.
  - `out_valid = 0`.
  - `out_sum = 0`.
  - `out_cout = 0`.
  - `out_overflow = 0`.
  - `out_count = 0`.
- Throughput: one beat accepted per cycle while in ACCUM.
- Latency: the last beat is accepted at edge k; `out_valid = 1` is visible after edge k, in cycle k+1.
- `in_ready` is 0 for every cycle `out_valid` is 1. There is no overlap of input acceptance and result hold.
- With `out_ready` held at 1:
  - HOLD lasts exactly 1 cycle.
  - An n-beat packet occupies n+1 cycles back-to-back.
  - The next packet's first beat is accepted in the cycle after the transfer.
- Backpressure: if `out_ready = 0`, HOLD persists indefinitely and `out_*` stay constant.
- The adder is combinational between `acc`/`in_data` and the registers, so one adder delay sits in the critical path. There is no pipelining.

## Test plan
- Reset, then one beat 0x00000005 with last, `out_ready = 1` -> after 1 cycle: `out_valid = 1`, `out_sum = 5`, `out_count = 1`, `out_cout = 0`, `out_overflow = 0`; the next cycle `in_ready = 1`.
- Packet 10, -3, 7 (last), one beat per cycle -> `out_sum = 14`, `out_count = 3`, `out_overflow = 0`; `out_valid` rises the cycle after the third beat.
- Packet 0x7FFFFFFF, 0x00000001 (last) -> `out_sum = 0x80000000`, `out_overflow = 1`, `out_cout = 0`.
- Packet 0xFFFFFFFF, 0x00000001 (last) -> `out_sum = 0`, `out_cout = 1`, `out_overflow = 0`.
- Backpressure: hold `out_ready = 0` for 5 cycles after a result -> `out_valid = 1` and `in_ready = 0` throughout, with `out_*` stable and offered input beats not accepted. Then raise `out_ready` -> one transfer, then ACCUM.
- Assert `rst` after 2 beats of a 4-beat packet -> outputs at reset values. A fresh packet 1, 2 (last) gives `out_sum = 3` and `out_count = 2`, with no residue from the aborted packet.
